compl_serial_decoder: RTL and testbench
=======================================

// Module: compl_serial_decoder
// PURPOSE
//  Bit-serial complement decoder: accepts an N-bit word coded in one's or two's complement and
//  returns sign + unsigned magnitude. Inverse of the combinational compl1 complementer; sits on its
//  output side in the P01 datapath. Valid/ready handshake on both sides, one word in flight.
// PARAMETERS
//  N        4   word width in bits (N >= 2)
//  CNT_W    $clog2(N)  bit-counter width (derived, not overridden)
// PORTS
//  clk        in   1  rising-edge clock, single clock domain
//  reset      in   1  asynchronous, active-high reset
//  in_valid   in   1  in_data/in_cp1 valid
//  in_ready   out  1  decoder can accept a word
//  in_data    in   N  complement-coded word
//  in_cp1     in   1  1 = one's complement, 0 = two's complement (same coding as compl1 cp1)
//  out_valid  out  1  out_sign/out_mag valid, held until accepted
//  out_ready  in   1  consumer accepts result
//  out_sign   out  1  in_data[N-1] of the accepted word
//  out_mag    out  N  unsigned magnitude
//  out_negzero out 1  (COMPL_FLAGS_EN only) one's-complement negative zero
//  out_minneg  out 1  (COMPL_FLAGS_EN only) two's-complement most-negative value
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; in_ready=1 after release; out_valid=0, out_sign=0,
//    out_mag=0, flags=0, internal shift/counter regs=0. Word in flight is discarded.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE. in_ready = (state==IDLE), combinational from state only.
//  - IDLE: on in_valid&&in_ready edge latch sr<=in_data, sign<=in_data[N-1], mode<=in_cp1,
//    cnt<=0, seen_one<=0, out_mag<=0; go SHIFT.
//  - SHIFT: one bit per cycle, LSB first. b=sr[0]; obit = sign==0 ? b : mode ? ~b : (seen_one ? ~b : b);
//    seen_one|=b; out_mag<={obit,out_mag[N-1:1]}; sr>>=1; cnt++. At cnt==N-1 go DONE.
//  - Latency: out_valid rises N clock edges after the accept edge; throughput one word per N+2 cycles
//    min (accept, N shifts, handoff).
//  - DONE: out_valid=1; out_sign/out_mag/flags stable. out_ready=1 -> IDLE, out_valid drops next edge.
//    out_ready low holds DONE indefinitely; in_valid ignored (in_ready=0) while busy.
//  - in_valid/in_data changes during SHIFT/DONE have no effect. out_ready in IDLE/SHIFT is ignored.
//  - Two's-complement most-negative (1 followed by zeros) yields out_mag = 2^(N-1) (fits unsigned N).
//  - One's-complement all-ones yields out_sign=1, out_mag=0 (negative zero, sign kept raw).
// CONFIGURATION
//  - COMPL_FLAGS_EN defined: out_negzero = mode&&sign&&(word all ones);
//    out_minneg = !mode&&sign&&(lower N-1 bits zero); computed at accept, registered, valid with
//    out_valid, cleared on reset and on leaving DONE.
//  - COMPL_FLAGS_EN undefined: both ports and their logic absent; all else identical.
// STRUCTURE
//  - Shared package compl_pkg: state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2),
//    mode constants CP2=1'b0, CP1=1'b1.
//  - One sub-module: compl_bit_slice (b, sign, mode, seen_one -> obit, seen_one_next), combinational;
//    top holds FSM, shift reg, counter, output regs.
// TESTING (N=4)
//  - 0100, cp1=0, out_ready=1 -> out_valid 4 edges after accept, sign=0, mag=0100, then IDLE.
//  - 1100, cp1=1 -> sign=1, mag=0011; 1100, cp1=0 -> sign=1, mag=0100.
//  - 1000, cp1=0 -> sign=1, mag=1000, out_minneg=1 (flags build); 1111, cp1=1 -> mag=0000, out_negzero=1.
//  - out_ready low 3 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; release -> IDLE.
//  - reset asserted on 2nd SHIFT cycle -> immediately out_valid=0, mag=0; after release in_ready=1,
//    next word 0011 cp1=0 decodes to sign=0, mag=0011.
//  - Back-to-back words with in_valid held high -> each accepted only in IDLE, results in order.

Source files
------------

// File: rtl/compl_pkg.sv
// Shared definitions for the bit-serial complement decoder: FSM state encoding
// and coding-mode constants (mode bit matches the compl1 cp1 input).
package compl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic CP2 = 1'b0;
  localparam logic CP1 = 1'b1;

endpackage

// File: rtl/compl_serial_decoder_if.sv
// Handshake bundle for compl_serial_decoder: word-in and result-out channels.
// COMPL_FLAGS_EN adds the negative-zero / most-negative flag signals.
interface compl_serial_decoder_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_cp1;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [N-1:0] out_mag;
`ifdef COMPL_FLAGS_EN
  logic         out_negzero;
  logic         out_minneg;

  modport master (
    output in_valid, in_data, in_cp1, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_negzero, out_minneg
  );

  modport slave (
    input  in_valid, in_data, in_cp1, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_negzero, out_minneg
  );
`else
  modport master (
    output in_valid, in_data, in_cp1, out_ready,
    input  in_ready, out_valid, out_sign, out_mag
  );

  modport slave (
    input  in_valid, in_data, in_cp1, out_ready,
    output in_ready, out_valid, out_sign, out_mag
  );
`endif
endinterface

// File: rtl/compl_bit_slice.sv
// One serial decode step: maps a coded bit (LSB first) to its magnitude bit.
// Two's complement negation copies bits up to the first 1, then inverts.
module compl_bit_slice
  import compl_pkg::*;
(
  input  logic i_b,
  input  logic i_sign,
  input  logic i_mode,
  input  logic i_seen_one,
  output logic o_obit,
  output logic o_seen_one_next
);

  always_comb begin
    o_obit = i_b;
    if (i_sign) begin
      if (i_mode == CP1) begin
        o_obit = ~i_b;
      end else if (i_seen_one) begin
        o_obit = ~i_b;
      end
    end
  end

  assign o_seen_one_next = i_seen_one | i_b;

endmodule

// File: rtl/compl_serial_decoder.sv
// Bit-serial one's/two's complement to sign+magnitude decoder, one word in flight.
// Optional COMPL_FLAGS_EN adds registered negative-zero / most-negative flags.
module compl_serial_decoder
  import compl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  compl_serial_decoder_if.slave bus
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [N-1:0]     r_sr;
  logic             r_sign;
  logic             r_mode;
  logic             r_seen_one;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_mag;
  logic             w_accept;
  logic             w_last;
  logic             w_obit;
  logic             w_seen_one_next;

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_sign  = r_sign;
  assign bus.out_mag   = r_mag;

  assign w_accept = bus.in_valid && (r_state == ST_IDLE);
  assign w_last   = (r_cnt == CNT_W'(N - 1));

  compl_bit_slice u_slice (
    .i_b             (r_sr[0]),
    .i_sign          (r_sign),
    .i_mode          (r_mode),
    .i_seen_one      (r_seen_one),
    .o_obit          (w_obit),
    .o_seen_one_next (w_seen_one_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)      w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_last)        w_state_next = ST_DONE;
      ST_DONE:  if (bus.out_ready) w_state_next = ST_IDLE;
      default:                     w_state_next = ST_IDLE;
    endcase
  end

  // Magnitude fills from the top so the LSB-first stream lands in place after N shifts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr       <= '0;
      r_sign     <= 1'b0;
      r_mode     <= 1'b0;
      r_seen_one <= 1'b0;
      r_cnt      <= '0;
      r_mag      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sr       <= bus.in_data;
            r_sign     <= bus.in_data[N-1];
            r_mode     <= bus.in_cp1;
            r_seen_one <= 1'b0;
            r_cnt      <= '0;
            r_mag      <= '0;
          end
        end
        ST_SHIFT: begin
          r_mag      <= {w_obit, r_mag[N-1:1]};
          r_sr       <= r_sr >> 1;
          r_seen_one <= w_seen_one_next;
          r_cnt      <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef COMPL_FLAGS_EN
  logic r_negzero;
  logic r_minneg;

  assign bus.out_negzero = r_negzero;
  assign bus.out_minneg  = r_minneg;

  // Flags are judged on the raw word at accept time and dropped once the result is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_negzero <= 1'b0;
      r_minneg  <= 1'b0;
    end else if (w_accept) begin
      r_negzero <= (bus.in_cp1 == CP1) && bus.in_data[N-1] && (&bus.in_data);
      r_minneg  <= (bus.in_cp1 == CP2) && bus.in_data[N-1] && (bus.in_data[N-2:0] == '0);
    end else if ((r_state == ST_DONE) && bus.out_ready) begin
      r_negzero <= 1'b0;
      r_minneg  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_compl_serial_decoder.sv
// Scoreboard bench for compl_serial_decoder (N=4): stimulus pushes expected results,
// a negedge monitor pops and compares on every accepted output.
module tb_compl_serial_decoder;

  localparam int N = 4;

  typedef struct {
    logic         sign;
    logic [N-1:0] mag;
    logic         nz;
    logic         mn;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  compl_serial_decoder_if #(.N(N)) bus ();

  compl_serial_decoder #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_pushed  = 0;
  int   n_results = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each result at the point the consumer accepts it.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got sign=%0b mag=%b with empty scoreboard",
                 bus.out_sign, bus.out_mag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_results++;
        $display("result %0d: sign=%0b mag=%b (expected sign=%0b mag=%b)",
                 n_results, bus.out_sign, bus.out_mag, e.sign, e.mag);
        chk("out_sign", 32'(bus.out_sign), 32'(e.sign));
        chk("out_mag", 32'(bus.out_mag), 32'(e.mag));
`ifdef COMPL_FLAGS_EN
        chk("out_negzero", 32'(bus.out_negzero), 32'(e.nz));
        chk("out_minneg", 32'(bus.out_minneg), 32'(e.mn));
`endif
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the accept edge.
  task automatic send(input logic [N-1:0] d, input logic c, input logic es,
                      input logic [N-1:0] em, input logic enz, input logic emn,
                      input logic keep_valid);
    int t;
    exp_t e;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_cp1   = c;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    e.sign = es; e.mag = em; e.nz = enz; e.mn = emn;
    sb.push_back(e);
    n_pushed++;
    $display("send data=%b cp1=%0b", d, c);
    @(posedge clk); #1;
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  logic [N-1:0] v_data [7] = '{4'b1100, 4'b1100, 4'b1000, 4'b1111, 4'b1111, 4'b0111, 4'b0000};
  logic         v_cp1  [7] = '{1'b1,    1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b1};
  logic         v_sign [7] = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b0};
  logic [N-1:0] v_mag  [7] = '{4'b0011, 4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0111, 4'b0000};
  logic         v_nz   [7] = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b0,    1'b0,    1'b0};
  logic         v_mn   [7] = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0};

  logic [N-1:0] b_data [5] = '{4'b0111, 4'b1001, 4'b1001, 4'b1000, 4'b0000};
  logic         b_cp1  [5] = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
  logic         b_sign [5] = '{1'b0,    1'b1,    1'b1,    1'b1,    1'b0};
  logic [N-1:0] b_mag  [5] = '{4'b0111, 4'b0110, 4'b0111, 4'b0111, 4'b0000};

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_cp1    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_sign", 32'(bus.out_sign), 32'd0);
    chk("reset_out_mag", 32'(bus.out_mag), 32'd0);
`ifdef COMPL_FLAGS_EN
    chk("reset_flags", 32'({bus.out_negzero, bus.out_minneg}), 32'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Latency: out_valid rises N edges after the accept edge, then back to IDLE
    send(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
    wait_out_valid(n);
    chk("latency_edges", 32'(n), 32'd4);
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Directed decode table
    for (int i = 0; i < 7; i++) begin
      send(v_data[i], v_cp1[i], v_sign[i], v_mag[i], v_nz[i], v_mn[i], 1'b0);
    end
    wait_out_valid(n);
    @(posedge clk); #1;

    // Backpressure: hold DONE three cycles with a competing word offered
    bus.out_ready = 1'b0;
    send(4'b1100, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
    wait_out_valid(n);
    chk("hold_reached_done", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b0001;
    bus.in_cp1   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_out_sign", 32'(bus.out_sign), 32'd1);
      chk("hold_out_mag", 32'(bus.out_mag), 32'(4'b0011));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset on the second SHIFT cycle discards the word in flight
    send(4'b0101, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset_out_mag", 32'(bus.out_mag), 32'd0);
    n_pushed -= sb.size();
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("postreset_in_ready", 32'(bus.in_ready), 32'd1);
    send(4'b0011, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);
    wait_out_valid(n);
    @(posedge clk); #1;

    // Back-to-back with in_valid held high
    for (int i = 0; i < 5; i++) begin
      send(b_data[i], b_cp1[i], b_sign[i], b_mag[i], 1'b0, 1'b0, 1'b1);
    end
    bus.in_valid = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("result_count", 32'(n_results), 32'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
